// File: rtl/mips_cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mips_cache_mem_arbiter_if
//
// Bundles every non-clock signal of the cache/memory arbiter:
//   - instruction-cache fill port   (i_req, i_addr -> i_data, i_valid)
//   - data-cache fill/write port    (d_rd_req, d_wr_req, d_addr, d_writedata,
//                                    d_byteenable -> d_data, d_valid, d_wr_done)
//   - Avalon-MM memory master port  (avm_* signals)
//   - status                        (busy, dbg_state)
//
// Modports:
//   master : the arbiter itself (drives fill results and the avm_* strobes)
//   slave  : the surroundings (caches + memory), i.e. what a testbench drives
//
// Handshake semantics (one place, applies to the whole bundle):
//   - Cache requests (i_req, d_rd_req, d_wr_req) are levels. A cache holds its
//     request until the matching one-cycle pulse (i_valid, d_valid,
//     d_wr_done) is seen, then drops it in that same cycle.
//   - Avalon-MM: a read/write is accepted on the first clock edge where the
//     strobe is high and avm_waitrequest is low. Address, data and byte
//     enables are held stable while avm_waitrequest is high.
//   - dbg_state mirrors the arbiter FSM state for checkers:
//     0 IDLE, 1 I_RD, 2 D_RD, 3 D_WR, 4 RESP.
// ---------------------------------------------------------------------------
interface mips_cache_mem_arbiter_if;
    // Instruction-cache side
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_valid;

    // Data-cache side
    logic        d_rd_req;
    logic        d_wr_req;
    logic [31:0] d_addr;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_data;
    logic        d_valid;
    logic        d_wr_done;

    // Avalon-MM master
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    // Status
    logic        busy;
    logic [2:0]  dbg_state;

    modport master (
        input  i_req, i_addr,
        output i_data, i_valid,
        input  d_rd_req, d_wr_req, d_addr, d_writedata, d_byteenable,
        output d_data, d_valid, d_wr_done,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata,
        output busy, dbg_state
    );

    modport slave (
        output i_req, i_addr,
        input  i_data, i_valid,
        output d_rd_req, d_wr_req, d_addr, d_writedata, d_byteenable,
        input  d_data, d_valid, d_wr_done,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata,
        input  busy, dbg_state
    );
endinterface

// File: rtl/mips_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_cache_mem_arbiter
//
// Miss/fill sequencer sitting between the instruction cache, the data cache
// and the CPU's single Avalon-MM memory master. Requests from both caches are
// arbitrated round-robin; exactly one memory transaction runs at a time.
// Fill data returns to the requesting cache together with a one-cycle valid
// pulse; data-cache write-throughs complete with a one-cycle done pulse.
//
// Parameters:
//   RESET_LAST_D : last-grant value after reset (1 = data side was last
//                  served, so the instruction side wins the first tie)
//
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : mips_cache_mem_arbiter_if.master (cache ports, avm port, busy,
//         dbg_state)
//
// Timing (zero-wait memory): request seen in cycle N -> avm strobe in N+1 ->
// valid/done pulse in N+2 (RESP) -> back in IDLE at N+3. Every waitrequest
// cycle stretches the strobe phase by one cycle.
// ---------------------------------------------------------------------------
module mips_cache_mem_arbiter #(
    parameter bit RESET_LAST_D = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_cache_mem_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state;
    state_t      state_n;

    // last_d = 1 means the data side received the most recent grant
    logic        last_d;
    logic        last_d_n;

    // Transaction registers latched at grant; requester inputs are ignored
    // from then on so the bus stays stable while waitrequest is high.
    logic [31:0] addr_q;
    logic [31:0] addr_n;
    logic [31:0] wdata_q;
    logic [31:0] wdata_n;
    logic [3:0]  be_q;
    logic [3:0]  be_n;

    // Registered strobes and result outputs
    logic        read_q;
    logic        read_n;
    logic        write_q;
    logic        write_n;
    logic [31:0] i_data_q;
    logic [31:0] i_data_n;
    logic [31:0] d_data_q;
    logic [31:0] d_data_n;
    logic        i_valid_q;
    logic        i_valid_n;
    logic        d_valid_q;
    logic        d_valid_n;
    logic        wr_done_q;
    logic        wr_done_n;

    // Arbitration terms
    logic        i_pend;
    logic        d_pend;
    logic        grant_i;
    logic        grant_d;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Defaults: hold everything, no pulses
        state_n   = state;
        last_d_n  = last_d;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        be_n      = be_q;
        i_data_n  = i_data_q;
        d_data_n  = d_data_q;
        i_valid_n = 1'b0;
        d_valid_n = 1'b0;
        wr_done_n = 1'b0;

        i_pend = bus.i_req;
        d_pend = bus.d_rd_req | bus.d_wr_req;

        // Round-robin: on a tie the side that was not served last wins
        grant_i = i_pend & (~d_pend | last_d);
        grant_d = d_pend & (~i_pend | ~last_d);

        case (state)
            IDLE: begin
                if (grant_i) begin
                    addr_n   = bus.i_addr & 32'hFFFF_FFFC;
                    be_n     = 4'b1111;
                    last_d_n = 1'b0;
                    state_n  = I_RD;
                end else if (grant_d) begin
                    addr_n   = bus.d_addr & 32'hFFFF_FFFC;
                    last_d_n = 1'b1;
                    // A pending write-through goes out before a fill so the
                    // fill observes the freshly written word.
                    if (bus.d_wr_req) begin
                        wdata_n = bus.d_writedata;
                        be_n    = bus.d_byteenable;
                        state_n = D_WR;
                    end else begin
                        be_n    = 4'b1111;
                        state_n = D_RD;
                    end
                end
            end

            I_RD: begin
                if (!bus.avm_waitrequest) begin
                    i_data_n  = bus.avm_readdata;
                    i_valid_n = 1'b1;
                    state_n   = RESP;
                end
            end

            D_RD: begin
                if (!bus.avm_waitrequest) begin
                    d_data_n  = bus.avm_readdata;
                    d_valid_n = 1'b1;
                    state_n   = RESP;
                end
            end

            D_WR: begin
                if (!bus.avm_waitrequest) begin
                    wr_done_n = 1'b1;
                    state_n   = RESP;
                end
            end

            // RESP holds for a full cycle so the served cache has dropped
            // its level request before IDLE samples requests again.
            RESP: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Strobes are registered copies of "next state is a bus state",
        // which makes them rise the cycle after the grant and fall on the
        // edge that accepts the transfer.
        read_n  = (state_n == I_RD) || (state_n == D_RD);
        write_n = (state_n == D_WR);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= RESET_LAST_D;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            i_data_q  <= 32'd0;
            d_data_q  <= 32'd0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state     <= state_n;
            last_d    <= last_d_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            be_q      <= be_n;
            read_q    <= read_n;
            write_q   <= write_n;
            i_data_q  <= i_data_n;
            d_data_q  <= d_data_n;
            i_valid_q <= i_valid_n;
            d_valid_q <= d_valid_n;
            wr_done_q <= wr_done_n;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.i_data         = i_data_q;
    assign bus.i_valid        = i_valid_q;
    assign bus.d_data         = d_data_q;
    assign bus.d_valid        = d_valid_q;
    assign bus.d_wr_done      = wr_done_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = read_q;
    assign bus.avm_write      = write_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_byteenable = be_q;
    assign bus.busy           = (state != IDLE);
    assign bus.dbg_state      = state;

endmodule

// File: tb/tb_mips_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_cache_mem_arbiter
//
// Directed scenarios followed by randomized rounds. Each randomized round
// raises a random mix of instruction fill, data fill and data write
// requests at once; a reference model replays the round-robin rule on the
// set of pending requests to produce the expected order of transactions,
// which the bench then plays out as memory with random wait states.
// ---------------------------------------------------------------------------
module tb_mips_cache_mem_arbiter;

    localparam logic [1:0] K_I  = 2'd0;
    localparam logic [1:0] K_DR = 2'd1;
    localparam logic [1:0] K_DW = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_cache_mem_arbiter_if bus ();

    mips_cache_mem_arbiter #(
        .RESET_LAST_D(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [1:0]  exp_q[$];
    bit          model_last_d;
    logic [31:0] seen_i_data;
    logic [31:0] seen_d_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.i_req           = 1'b0;
        bus.i_addr          = 32'd0;
        bus.d_rd_req        = 1'b0;
        bus.d_wr_req        = 1'b0;
        bus.d_addr          = 32'd0;
        bus.d_writedata     = 32'd0;
        bus.d_byteenable    = 4'd0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_i_data = 32'd0;
        seen_d_data = 32'd0;
    endtask

    // Plays memory for one transaction: waits for the strobe, checks the
    // bus, stretches with 'waits' waitrequest cycles, then checks the RESP
    // cycle. exp_lat = expected negedges until the strobe (0 = don't care).
    task automatic run_tx(input logic [1:0] kind, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int waits, input logic [31:0] rdata,
                          input bit drop, input int exp_lat);
        int n;
        bit found;
        logic [31:0] waddr;
        found = 1'b0;
        n = 0;
        waddr = addr & 32'hFFFF_FFFC;
        bus.avm_waitrequest = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (bus.avm_read || bus.avm_write) begin
                found = 1'b1;
                n = t;
                break;
            end
        end
        check("strobe_seen", 32'(found), 32'd1);
        if (!found) return;
        if (exp_lat > 0) check("strobe_latency", 32'(n), 32'(exp_lat));
        check("avm_read", 32'(bus.avm_read), 32'(kind != K_DW));
        check("avm_write", 32'(bus.avm_write), 32'(kind == K_DW));
        check("avm_address", bus.avm_address, waddr);
        check("avm_byteenable", 32'(bus.avm_byteenable), (kind == K_DW) ? 32'(be) : 32'hF);
        if (kind == K_DW) check("avm_writedata", bus.avm_writedata, wdata);
        bus.avm_readdata    = rdata;
        bus.avm_waitrequest = (waits > 0);
        for (int k = 1; k <= waits; k++) begin
            @(negedge clk);
            check("hold_strobe", 32'(bus.avm_read | bus.avm_write), 32'd1);
            check("hold_address", bus.avm_address, waddr);
            check("hold_no_pulse", 32'({bus.i_valid, bus.d_valid, bus.d_wr_done}), 32'd0);
            if (k == waits) bus.avm_waitrequest = 1'b0;
        end
        @(negedge clk);
        check("resp_strobes_low", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        check("resp_i_valid", 32'(bus.i_valid), 32'(kind == K_I));
        check("resp_d_valid", 32'(bus.d_valid), 32'(kind == K_DR));
        check("resp_d_wr_done", 32'(bus.d_wr_done), 32'(kind == K_DW));
        check("resp_busy", 32'(bus.busy), 32'd1);
        if (kind == K_I) seen_i_data = rdata;
        if (kind == K_DR) seen_d_data = rdata;
        check("i_data", bus.i_data, seen_i_data);
        check("d_data", bus.d_data, seen_d_data);
        if (drop) begin
            case (kind)
                K_I:     bus.i_req    = 1'b0;
                K_DR:    bus.d_rd_req = 1'b0;
                default: bus.d_wr_req = 1'b0;
            endcase
        end
        bus.avm_readdata = $urandom;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          i_on;
        int          dsel;
        bit          first;
        logic [1:0]  k;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [3:0]  be;
        int          pulses;
        logic [1:0]  dq[$];
        bit          i_p;

        rst = 1'b1;
        idle_inputs();
        seen_i_data = 32'd0;
        seen_d_data = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_strobes", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        check("rst_pulses", 32'({bus.i_valid, bus.d_valid, bus.d_wr_done}), 32'd0);
        check("rst_i_data", bus.i_data, 32'd0);
        check("rst_d_data", bus.d_data, 32'd0);
        check("rst_address", bus.avm_address, 32'd0);
        check("rst_byteenable", 32'(bus.avm_byteenable), 32'd0);
        rst = 1'b0;

        // 1: instruction fill, zero wait, unaligned address
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h1000_0006;
        run_tx(K_I, 32'h1000_0006, 32'd0, 4'd0, 0, 32'hDEADBEEF, 1'b1, 1);
        @(negedge clk);
        check("t1_busy_low", 32'(bus.busy), 32'd0);
        check("t1_single_pulse", 32'(bus.i_valid), 32'd0);

        // 2: data fill with 3 waitrequest cycles
        bus.d_rd_req = 1'b1;
        bus.d_addr   = 32'h0000_0020;
        run_tx(K_DR, 32'h20, 32'd0, 4'd0, 3, 32'h1234_5678, 1'b1, 1);
        @(negedge clk);
        check("t2_single_pulse", 32'(bus.d_valid), 32'd0);
        check("t2_busy_low", 32'(bus.busy), 32'd0);

        // 3: simultaneous requests after reset, held: I, D, I, D
        do_reset();
        bus.i_req    = 1'b1;
        bus.i_addr   = 32'h0000_0100;
        bus.d_rd_req = 1'b1;
        bus.d_addr   = 32'h0000_0200;
        run_tx(K_I,  32'h100, 32'd0, 4'd0, 0, 32'hA000_0001, 1'b0, 1);
        run_tx(K_DR, 32'h200, 32'd0, 4'd0, 1, 32'hA000_0002, 1'b0, 2);
        run_tx(K_I,  32'h100, 32'd0, 4'd0, 0, 32'hA000_0003, 1'b0, 2);
        run_tx(K_DR, 32'h200, 32'd0, 4'd0, 0, 32'hA000_0004, 1'b0, 2);
        bus.i_req    = 1'b0;
        bus.d_rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_idle", 32'(bus.busy), 32'd0);

        // 4: write-through with partial byte enables
        bus.d_wr_req     = 1'b1;
        bus.d_addr       = 32'h0000_0044;
        bus.d_writedata  = 32'h0000_ABCD;
        bus.d_byteenable = 4'b0011;
        run_tx(K_DW, 32'h44, 32'h0000_ABCD, 4'b0011, 2, 32'hFFFF_FFFF, 1'b1, 1);
        @(negedge clk);
        check("t4_single_done", 32'(bus.d_wr_done), 32'd0);

        // 5: reset while a data fill is stalled by waitrequest
        bus.d_rd_req = 1'b1;
        bus.d_addr   = 32'h0000_0080;
        bus.avm_waitrequest = 1'b1;
        first = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.avm_read) begin
                first = 1'b1;
                break;
            end
        end
        check("t5_read_started", 32'(first), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_read_dropped", 32'(bus.avm_read), 32'd0);
        check("t5_busy_low", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        bus.d_rd_req = 1'b0;
        bus.avm_waitrequest = 1'b0;
        seen_i_data = 32'd0;
        seen_d_data = 32'd0;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.d_valid) pulses++;
        end
        check("t5_no_d_valid", 32'(pulses), 32'd0);

        // 6: write and fill requested together: write goes first
        bus.d_rd_req     = 1'b1;
        bus.d_wr_req     = 1'b1;
        bus.d_addr       = 32'h0000_0307;
        bus.d_writedata  = 32'hCAFE_F00D;
        bus.d_byteenable = 4'b1100;
        run_tx(K_DW, 32'h307, 32'hCAFE_F00D, 4'b1100, 0, 32'h0, 1'b1, 1);
        run_tx(K_DR, 32'h307, 32'd0, 4'd0, 0, 32'h5555_AAAA, 1'b1, 2);
        @(negedge clk);
        check("t6_idle", 32'(bus.busy), 32'd0);

        // Randomized rounds against the round-robin model
        do_reset();
        model_last_d = 1'b1;
        for (int r = 0; r < 40; r++) begin
            i_on = 1'($urandom_range(0, 1));
            dsel = $urandom_range(0, 3);
            if (!i_on && dsel == 0) i_on = 1'b1;
            ia = $urandom;
            da = $urandom;
            wd = $urandom;
            be = 4'($urandom_range(1, 15));

            // Model: serve pending requests one at a time, tie goes to the
            // side not served last, a write beats a fill on the data side.
            dq.delete();
            if (dsel >= 2) dq.push_back(K_DW);
            if (dsel == 1 || dsel == 3) dq.push_back(K_DR);
            i_p = i_on;
            while (i_p || dq.size() > 0) begin
                if (dq.size() > 0 && (!i_p || !model_last_d)) begin
                    exp_q.push_back(dq.pop_front());
                    model_last_d = 1'b1;
                end else begin
                    exp_q.push_back(K_I);
                    i_p = 1'b0;
                    model_last_d = 1'b0;
                end
            end

            bus.i_req        = i_on;
            bus.i_addr       = ia;
            bus.d_rd_req     = (dsel == 1 || dsel == 3);
            bus.d_wr_req     = (dsel >= 2);
            bus.d_addr       = da;
            bus.d_writedata  = wd;
            bus.d_byteenable = be;
            first = 1'b1;
            while (exp_q.size() > 0) begin
                k = exp_q.pop_front();
                run_tx(k, (k == K_I) ? ia : da, wd, be, $urandom_range(0, 3),
                       $urandom, 1'b1, first ? 1 : 2);
                first = 1'b0;
            end
            @(negedge clk);
            check("rnd_idle_after_round", 32'(bus.busy), 32'd0);
            check("rnd_no_strobe", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_cache_mem_arbiter.md
Name: mips_cache_mem_arbiter

Overview:
- Miss/fill sequencer between the instruction cache, the data cache and the single Avalon-MM memory master port of the CPU.
- Accepts level-held fill requests from both caches and write-through requests from the data cache.
- Arbitrates round-robin, runs one memory transaction at a time, honouring waitrequest.
- Returns fill data to the requesting cache with a one-cycle valid pulse, which is the cache's data_valid input.

Parameters:
RESET_LAST_D, 1, value of the last-grant register after reset (1 = data side last served, so the instruction side wins the first tie).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  instruction-cache fill request (cache stall), level
i_addr  in  32  instruction fill byte address
i_data  out  32  fill data to instruction cache
i_valid  out  1  one-cycle fill-valid pulse to instruction cache
d_rd_req  in  1  data-cache fill request, level
d_wr_req  in  1  data-cache write-through request, level
d_addr  in  32  data-side byte address
d_writedata  in  32  write data
d_byteenable  in  4  write byte enables
d_data  out  32  fill data to data cache
d_valid  out  1  one-cycle fill-valid pulse to data cache
d_wr_done  out  1  one-cycle write-complete pulse
avm_address  out  32  memory address, word aligned
avm_read  out  1  memory read strobe
avm_write  out  1  memory write strobe
avm_writedata  out  32  memory write data
avm_byteenable  out  4  memory byte enables
avm_waitrequest  in  1  memory stall
avm_readdata  in  32  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state IDLE; last_grant = RESET_LAST_D.
  - All outputs 0, including i_data and d_data.
- Reset mid-transaction: the next edge forces IDLE and drops avm_read/avm_write. No valid or done pulse is issued.
- States: IDLE, I_RD, D_RD, D_WR, RESP.
- IDLE:
  - The instruction side is pending if i_req. The data side is pending if d_rd_req | d_wr_req.
  - One side pending: grant it.
  - Both pending: grant the side not equal to last_grant.
  - On grant, latch the address as {addr[31:2],2'b00}. For a data write also latch writedata and byteenable; for reads latch byteenable 4'b1111.
  - Update last_grant, then go to I_RD, D_RD or D_WR. d_wr_req takes precedence over d_rd_req when both are high.
  - avm_read/avm_write are registered and assert in the cycle after the grant.
- I_RD / D_RD:
  - avm_read=1 with address held stable while waitrequest=1.
  - On the first edge with waitrequest=0: capture readdata into i_data or d_data, drop avm_read, go to RESP.
- D_WR:
  - avm_write=1 with address, writedata and byteenable held while waitrequest=1.
  - On waitrequest=0: drop avm_write, go to RESP.
- RESP (one cycle):
  - Exactly one of i_valid, d_valid or d_wr_done is 1, matching the granted transaction.
  - Then return to IDLE.
  - Because RESP lasts a full cycle, the served cache has cleared its stall before IDLE re-samples it, so the same miss is never reissued.
- Latency: request seen at cycle N gives avm strobe at N+1. Zero-wait memory gives the valid pulse at N+2 and IDLE at N+3. Each waitrequest cycle adds 1.
- i_data/d_data hold their last fill value until the next fill on that side.
- Requester inputs are ignored after the grant latches them. Changes mid-transaction do not affect the bus.
- avm_read and avm_write are never high together.
- At most one transaction is outstanding.
- Starvation bound: a pending side is served within one transaction of the other side.

Test Plan:
1. i_req=1, i_addr=0x1000_0006, waitrequest=0, readdata=0xDEADBEEF -> avm_address=0x1000_0004 and avm_read=1 for one cycle at N+1; i_valid=1 with i_data=0xDEADBEEF at N+2; busy low at N+3.
2. d_rd_req=1, d_addr=0x20, waitrequest high 3 cycles -> avm_read and address stable for 4 cycles; d_valid pulses once, 1 cycle after waitrequest drops.
3. i_req and d_rd_req asserted in the same cycle after reset -> instruction read first, then data read. With both held continuously the grants alternate I,D,I,D.
4. d_wr_req=1, d_byteenable=4'b0011, d_writedata=0x0000ABCD, d_addr=0x44 -> avm_write=1 with byteenable 0011, data 0x0000ABCD, address 0x44; d_wr_done pulses once; avm_read stays 0.
5. rst asserted during D_RD with waitrequest=1 -> avm_read=0 and busy=0 after that edge; no d_valid ever pulses.
6. d_rd_req and d_wr_req both high -> write is issued first; read is issued after RESP and IDLE.
